mem_ctrl: RTL

//  Requester side of the single-port instruction/data RAM. Arbitrates between the CPU fetch port
//  (read-only) and the load/store port, then drives the RAM address/data_in/write_enable/read_enable

---
 rtl/mem_ctrl.sv | 141 ++++++++++++++
 1 files changed

// File: rtl/mem_ctrl.sv
// Single-port RAM requester: arbitrates the CPU fetch port and the load/store port, sequences the RAM pins.
// Optional write protection of the low address window is enabled by defining MEMCTRL_WPROT_EN.
module mem_ctrl #(
  parameter int              ADDR_W    = 12,
  parameter int              DATA_W    = 16,
  parameter int              MEM_WORDS = 2048,
  parameter int              RD_LAT    = 1,
  parameter logic [ADDR_W-1:0] PROT_TOP = 12'h0FF
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              if_req_valid,
  output logic              if_req_ready,
  input  logic [ADDR_W-1:0] if_addr,
  output logic              if_rsp_valid,
  output logic [DATA_W-1:0] if_rsp_data,
  input  logic              dm_req_valid,
  output logic              dm_req_ready,
  input  logic              dm_we,
  input  logic [ADDR_W-1:0] dm_addr,
  input  logic [DATA_W-1:0] dm_wdata,
  output logic              dm_rsp_valid,
  output logic [DATA_W-1:0] dm_rsp_data,
  output logic [ADDR_W-1:0] ram_address,
  output logic [DATA_W-1:0] ram_data_in,
  output logic              ram_write_enable,
  output logic              ram_read_enable,
  input  logic [DATA_W-1:0] ram_data_out,
  output logic              wprot_fault
);

`ifdef MEMCTRL_WPROT_EN
  localparam bit WPROT_EN = 1'b1;
`else
  localparam bit WPROT_EN = 1'b0;
`endif

  localparam int                CNT_W     = $clog2(RD_LAT + 1) + 1;
  localparam logic [CNT_W-1:0]  CNT_LAST  = CNT_W'(RD_LAT);
  localparam logic [ADDR_W:0]   MEM_LIMIT = (ADDR_W + 1)'(MEM_WORDS);

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_ACCESS,
    ST_RESP
  } state_t;

  state_t            r_state;
  state_t            w_state_next;
  logic [ADDR_W-1:0] r_addr;
  logic [DATA_W-1:0] r_wdata;
  logic              r_we;
  logic              r_port_dm;
  logic              r_last_grant_dm;
  logic [CNT_W-1:0]  r_cnt;
  logic [DATA_W-1:0] r_if_rsp_data;
  logic [DATA_W-1:0] r_dm_rsp_data;
  logic              r_wprot_fault;

  logic              w_grant_if;
  logic              w_grant_dm;
  logic              w_access_done;
  logic              w_in_range;
  logic              w_prot_hit;
  logic [DATA_W-1:0] w_capture;

  assign w_in_range = ({1'b0, r_addr} < MEM_LIMIT);
  assign w_prot_hit = WPROT_EN && r_we && (r_addr <= PROT_TOP);
  assign w_capture  = (r_we || !w_in_range) ? '0 : ram_data_out;

  // NOTE: every signal written here gets a default first, so no path leaves it unassigned (no latch).
  always_comb begin
    w_state_next  = r_state;
    w_grant_if    = 1'b0;
    w_grant_dm    = 1'b0;
    w_access_done = 1'b0;
    case (r_state)
      ST_IDLE: begin
        // On a conflict the requester that lost last time wins.
        w_grant_dm = dm_req_valid && (!if_req_valid || !r_last_grant_dm);
        w_grant_if = if_req_valid && !w_grant_dm;
        if (w_grant_dm || w_grant_if) w_state_next = ST_ACCESS;
      end
      ST_ACCESS: begin
        w_access_done = r_we || (r_cnt == CNT_LAST);
        if (w_access_done) w_state_next = ST_RESP;
      end
      ST_RESP:  w_state_next = ST_IDLE;
      default:  w_state_next = ST_IDLE;
    endcase
  end

  // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state         <= ST_IDLE;
      r_addr          <= '0;
      r_wdata         <= '0;
      r_we            <= 1'b0;
      r_port_dm       <= 1'b0;
      r_last_grant_dm <= 1'b0;
      r_cnt           <= '0;
      r_if_rsp_data   <= '0;
      r_dm_rsp_data   <= '0;
      r_wprot_fault   <= 1'b0;
    end else begin
      r_state <= w_state_next;
      if (w_grant_dm || w_grant_if) begin
        r_addr          <= w_grant_dm ? dm_addr : if_addr;
        r_we            <= w_grant_dm && dm_we;
        r_port_dm       <= w_grant_dm;
        r_last_grant_dm <= w_grant_dm;
        r_cnt           <= '0;
        if (w_grant_dm) r_wdata <= dm_wdata;
      end
      if (r_state == ST_ACCESS) begin
        r_cnt <= r_cnt + 1'b1;
        if (w_prot_hit) r_wprot_fault <= 1'b1;
        if (w_access_done) begin
          if (r_port_dm) r_dm_rsp_data <= w_capture;
          else           r_if_rsp_data <= w_capture;
        end
      end
    end
  end

  // Address and data only change on the accept edge, so they are stable whenever an enable is high.
  assign ram_address      = r_addr;
  assign ram_data_in      = r_wdata;
  assign ram_write_enable = (r_state == ST_ACCESS) && r_we && w_in_range && !w_prot_hit;
  assign ram_read_enable  = (r_state == ST_ACCESS) && !r_we && w_in_range;

  assign if_req_ready = w_grant_if;
  assign dm_req_ready = w_grant_dm;
  assign if_rsp_valid = (r_state == ST_RESP) && !r_port_dm;
  assign dm_rsp_valid = (r_state == ST_RESP) && r_port_dm;
  assign if_rsp_data  = r_if_rsp_data;
  assign dm_rsp_data  = r_dm_rsp_data;
  assign wprot_fault  = r_wprot_fault;

endmodule
